// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC sequencing, one-outstanding imem handshake, single-entry decode buffer.
// Optional misaligned-PC fault detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    // state | meaning
    // IDLE  | first cycle after reset
    // REQ   | presenting pc_in to instruction memory
    // WAIT  | request granted, waiting for its response
    // FULL  | instruction buffered for decode
    // FAULT | misaligned PC seen, waiting for a redirect
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, FAULT} state_t;

    state_t state;
    logic   drop;
    logic   misaligned;
    logic   issue;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned  = (pc_in[1:0] != 2'b00);
    assign imem_addr   = (state == REQ) ? pc_in : 32'h0;
    assign fetch_fault = (state == FAULT);
`else
    assign misaligned  = 1'b0;
    assign imem_addr   = (state == REQ) ? {pc_in[31:2], 2'b00} : 32'h0;
    assign fetch_fault = 1'b0;
`endif

    assign imem_req   = (state == REQ) && !misaligned;
    assign inst_valid = (state == FULL);
    assign issue      = imem_req && imem_gnt;

    always_comb begin
        pc_next = pc_in;
        if (reset)
            pc_next = RESET_PC;
        else if (redirect_valid && state != IDLE)
            pc_next = redirect_pc;
        else if (issue)
            pc_next = pc_in + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            drop    <= 1'b0;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (issue) begin
                        // A redirect coinciding with the grant still consumes the slot;
                        // its response must be thrown away.
                        inst_pc <= pc_in;
                        drop    <= redirect_valid;
                        state   <= WAIT;
                    end else if (!redirect_valid && misaligned) begin
                        state <= FAULT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop <= 1'b0;
                        if (drop || redirect_valid) begin
                            state <= REQ;
                        end else begin
                            inst  <= imem_rdata;
                            state <= FULL;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                FULL: begin
                    if (redirect_valid || inst_ready)
                        state <= REQ;
                end
                FAULT: begin
                    if (redirect_valid)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed corner sequences, randomized run
// against a transaction-level program-order model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // PC register owned by the bench
    always @(posedge clk) pc_in <= pc_next;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdir, input logic [31:0] rpc);
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        inst_ready     = rdy;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_ipc;
        logic [31:0] exp_pcn;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] eipc, input logic [31:0] epcn);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_ipc = eipc; v.exp_pcn = epcn;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g, rv, rdy, rd, mp;
        logic [31:0] rpc, ma, exp_pc, exp_pcn;
        int          mc, delivered;

        // zero-wait fetch from reset, then 5 cycles of decoder backpressure
        tbl[0]  = mk(0, 0, 0,          0, 0, 32'h0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 0, 0,          0, 1, 32'h0, 0, 32'h0, 32'h4);
        tbl[2]  = mk(0, 1, memf(32'h0), 0, 0, 32'h0, 0, 32'h0, 32'h4);
        tbl[3]  = mk(0, 0, 0,          1, 0, 32'h0, 1, 32'h0, 32'h4);
        tbl[4]  = mk(1, 0, 0,          0, 1, 32'h4, 0, 32'h0, 32'h8);
        tbl[5]  = mk(0, 1, memf(32'h4), 0, 0, 32'h0, 0, 32'h0, 32'h8);
        tbl[6]  = mk(0, 0, 0,          1, 0, 32'h0, 1, 32'h4, 32'h8);
        tbl[7]  = mk(1, 0, 0,          0, 1, 32'h8, 0, 32'h0, 32'hC);
        tbl[8]  = mk(0, 1, memf(32'h8), 0, 0, 32'h0, 0, 32'h0, 32'hC);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC);
        tbl[14] = mk(0, 0, 0,          1, 0, 32'h0, 1, 32'h8, 32'hC);

        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h55);
        tick(); tick();
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", fetch_fault, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready, 0, 0);
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].exp_req);
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].exp_ipc);
                chk($sformatf("tbl%0d_inst", i), inst, memf(tbl[i].exp_ipc));
            end
            chk($sformatf("tbl%0d_pc_next", i), pc_next, tbl[i].exp_pcn);
            tick();
        end

        // redirect while waiting on the response for 0xC
        drive(1, 0, 0, 0, 0, 0);
        chk("a_req", imem_req, 1);
        chk("a_addr", imem_addr, 32'hC);
        chk("a_pc_next", pc_next, 32'h10);
        tick();
        drive(0, 0, 0, 0, 1, 32'h100);
        chk("a_redir_pc_next", pc_next, 32'h100);
        chk("a_wait_req", imem_req, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("a_drop_valid", inst_valid, 0);
        tick();
        drive(0, 1, memf(32'hC), 0, 0, 0);
        chk("a_stale_pc_next", pc_next, 32'h100);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("a_stale_valid", inst_valid, 0);
        chk("a_new_req", imem_req, 1);
        chk("a_new_addr", imem_addr, 32'h100);
        chk("a_new_pc_next", pc_next, 32'h104);
        tick();
        drive(0, 1, memf(32'h100), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("a_valid", inst_valid, 1);
        chk("a_inst_pc", inst_pc, 32'h100);
        chk("a_inst", inst, memf(32'h100));

        // redirect and grant in the same REQ cycle
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h200);
        chk("b_req", imem_req, 1);
        chk("b_addr", imem_addr, 32'h104);
        chk("b_pc_next", pc_next, 32'h200);
        tick();
        drive(0, 1, memf(32'h104), 0, 0, 0);
        chk("b_drop_valid", inst_valid, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("b_stale_valid", inst_valid, 0);
        chk("b_new_req", imem_req, 1);
        chk("b_new_addr", imem_addr, 32'h200);
        tick();
        drive(0, 1, memf(32'h200), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("b_valid", inst_valid, 1);
        chk("b_inst_pc", inst_pc, 32'h200);
        chk("b_inst", inst, memf(32'h200));

        // redirect in FULL wins over a simultaneous inst_ready
        drive(0, 0, 0, 1, 1, 32'h300);
        chk("c_pc_next", pc_next, 32'h300);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("c_valid", inst_valid, 0);
        chk("c_req", imem_req, 1);
        chk("c_addr", imem_addr, 32'h300);
        tick();

        // reset while waiting; late response in the first post-reset cycle is ignored
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("d_rst_pc_next", pc_next, 32'h0);
        tick();
        chk("d_req", imem_req, 0);
        chk("d_addr", imem_addr, 32'h0);
        chk("d_valid", inst_valid, 0);
        chk("d_inst", inst, 32'h0);
        chk("d_inst_pc", inst_pc, 32'h0);
        chk("d_fault", fetch_fault, 0);
        reset = 1'b0;
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("d_late_valid", inst_valid, 0);
        chk("d_restart_req", imem_req, 1);
        chk("d_restart_addr", imem_addr, 32'h0);
        tick();
        drive(0, 1, memf(32'h0), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("d_valid_after", inst_valid, 1);
        chk("d_inst_pc_after", inst_pc, 32'h0);
        chk("d_inst_after", inst, memf(32'h0));

        // misaligned PC
        drive(0, 0, 0, 1, 1, 32'h6);
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 0, 0, 0, 0, 0);
        chk("e_req", imem_req, 0);
        chk("e_pc_next", pc_next, 32'h6);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("e_fault", fetch_fault, 1);
        chk("e_fault_req", imem_req, 0);
        chk("e_fault_pc_next", pc_next, 32'h6);
        tick();
        drive(0, 0, 0, 0, 1, 32'h20);
        chk("e_fault_held", fetch_fault, 1);
        chk("e_redir_pc_next", pc_next, 32'h20);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("e_fault_clear", fetch_fault, 0);
        chk("e_new_req", imem_req, 1);
        chk("e_new_addr", imem_addr, 32'h20);
        tick();
        drive(0, 1, memf(32'h20), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("e_valid", inst_valid, 1);
        chk("e_inst_pc", inst_pc, 32'h20);
`else
        drive(1, 0, 0, 0, 0, 0);
        chk("e_req", imem_req, 1);
        chk("e_addr_forced", imem_addr, 32'h4);
        chk("e_fault", fetch_fault, 0);
        chk("e_pc_next", pc_next, 32'hA);
        tick();
        drive(0, 1, memf(32'h4), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("e_valid", inst_valid, 1);
        chk("e_inst_pc", inst_pc, 32'h6);
        chk("e_fault_after", fetch_fault, 0);
`endif

        // randomized run: delivered instructions must follow program order from the last redirect
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        mp = 1'b0; mc = 0; ma = 32'h0; exp_pc = 32'h0; delivered = 0;
        for (int n = 0; n < 4000; n++) begin
            g   = imem_req && !mp && ($urandom_range(0, 3) != 0);
            rv  = mp && (mc == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom_range(0, 255) << 2;
            drive(g, rv, rv ? memf(ma) : $urandom, rdy, rd, rpc);
            exp_pcn = rd ? rpc : (imem_req && g) ? pc_in + 32'd4 : pc_in;
            chk("r_pc_next", pc_next, exp_pcn);
            chk("r_fault", fetch_fault, 0);
            if (imem_req) begin
                chk("r_addr", imem_addr, pc_in);
                chk("r_one_outstanding", mp, 0);
            end
            if (inst_valid && rdy && !rd) begin
                chk("r_inst_pc", inst_pc, exp_pc);
                chk("r_inst", inst, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (rd) exp_pc = rpc;
            if (rv) mp = 1'b0;
            if (g) begin
                mp = 1'b1;
                ma = imem_addr;
                mc = $urandom_range(0, 3);
            end else if (mp && mc > 0) begin
                mc--;
            end
            tick();
        end
        chk("r_progress", delivered > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
